// File: rtl/vip_rgb_sobel_edge.sv
// vip_rgb_sobel_edge: RGB888 -> BT.601 luma -> 3x3 Sobel magnitude vs threshold, one edge bit per pixel.
// Syncs are delayed 7 cycles to line up with the edge bit; a frame aborted by reset stays dark until fresh vsync.
module vip_rgb_sobel_edge #(
    parameter int IMG_HDISP = 320,
    parameter int IMG_VDISP = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       per_frame_vsync,
    input  logic       per_frame_href,
    input  logic       per_frame_clken,
    input  logic [7:0] per_img_red,
    input  logic [7:0] per_img_green,
    input  logic [7:0] per_img_blue,
    input  logic [7:0] Sobel_Threshold,
    output logic       post_frame_vsync,
    output logic       post_frame_href,
    output logic       post_frame_clken,
    output logic       post_img_Bit
);
    localparam int XW = $clog2(IMG_HDISP + 1);
    localparam int YW = $clog2(IMG_VDISP + 1);
    localparam int AW = $clog2(IMG_HDISP);

    logic             r_armed;
    logic             w_armed;
    logic [6:0]       r_vs, r_hr, r_ck;
    logic [15:0]      r_pr, r_pg, r_pb, r_sum;
    logic [7:0]       r_y;
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_yc;
    logic [7:0]       r_lb1 [IMG_HDISP];
    logic [7:0]       r_lb2 [IMG_HDISP];
    logic [2:0][2:0][7:0] r_w;
    logic             w_acc, w_inr;
    logic [AW-1:0]    w_idx;
    logic [7:0]       w_l1, w_l2;
    logic             r_ok4, r_ok5, r_ok6, r_bit;
    logic [10:0]      w_gx, w_gy, r_gx, r_gy, w_ax, w_ay;
    logic [20:0]      w_sx, w_sy, r_sq;
    logic [15:0]      w_th2;

    // Armed once vsync has been seen low since reset; until then the stream is gated off.
    assign w_armed = r_armed | ~per_frame_vsync;
    assign w_acc   = r_hr[2] & r_ck[2];
    assign w_inr   = r_x < XW'(IMG_HDISP);
    assign w_idx   = w_inr ? AW'(r_x) : '0;
    assign w_l1    = r_lb1[w_idx];
    assign w_l2    = r_lb2[w_idx];

    // Window row 0 = top (y-2), column 0 = left (x-2); 11-bit wraparound gives the signed result.
    assign w_gx = (11'(r_w[0][2]) + 11'({r_w[1][2], 1'b0}) + 11'(r_w[2][2]))
                - (11'(r_w[0][0]) + 11'({r_w[1][0], 1'b0}) + 11'(r_w[2][0]));
    assign w_gy = (11'(r_w[0][0]) + 11'({r_w[0][1], 1'b0}) + 11'(r_w[0][2]))
                - (11'(r_w[2][0]) + 11'({r_w[2][1], 1'b0}) + 11'(r_w[2][2]));
    assign w_ax  = r_gx[10] ? ~r_gx + 11'd1 : r_gx;
    assign w_ay  = r_gy[10] ? ~r_gy + 11'd1 : r_gy;
    assign w_sx  = {10'd0, w_ax} * {10'd0, w_ax};
    assign w_sy  = {10'd0, w_ay} * {10'd0, w_ay};
    assign w_th2 = {8'd0, Sobel_Threshold} * {8'd0, Sobel_Threshold};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed <= 1'b0;
            r_vs    <= '0;
            r_hr    <= '0;
            r_ck    <= '0;
            r_pr    <= '0;
            r_pg    <= '0;
            r_pb    <= '0;
            r_sum   <= '0;
            r_y     <= '0;
            r_x     <= '0;
            r_yc    <= '0;
            r_w     <= '0;
            r_ok4   <= 1'b0;
            r_ok5   <= 1'b0;
            r_ok6   <= 1'b0;
            r_gx    <= '0;
            r_gy    <= '0;
            r_sq    <= '0;
            r_bit   <= 1'b0;
        end else begin
            r_armed <= w_armed;
            r_vs    <= {r_vs[5:0], per_frame_vsync & w_armed};
            r_hr    <= {r_hr[5:0], per_frame_href & w_armed};
            r_ck    <= {r_ck[5:0], per_frame_clken & w_armed};
            r_pr    <= 16'(per_img_red) * 16'd77;
            r_pg    <= 16'(per_img_green) * 16'd150;
            r_pb    <= 16'(per_img_blue) * 16'd29;
            r_sum   <= r_pr + r_pg + r_pb;
            r_y     <= 8'(r_sum >> 8);
            r_x     <= !r_hr[2] ? '0 : w_acc ? r_x + XW'(1) : r_x;
            r_yc    <= !r_vs[2] ? '0 : (r_hr[3] & ~r_hr[2]) ? r_yc + YW'(1) : r_yc;
            if (w_acc) begin
                for (int r = 0; r < 3; r++) begin
                    r_w[r][0] <= r_w[r][1];
                    r_w[r][1] <= r_w[r][2];
                end
                r_w[0][2] <= w_l2;
                r_w[1][2] <= w_l1;
                r_w[2][2] <= r_y;
            end
            r_ok4 <= w_acc & (r_x >= XW'(2)) & (r_yc >= YW'(2));
            r_gx  <= w_gx;
            r_gy  <= w_gy;
            r_ok5 <= r_ok4;
            r_sq  <= w_sx + w_sy;
            r_ok6 <= r_ok5;
            r_bit <= r_ok6 & (r_sq > {5'd0, w_th2});
        end
    end

    // Line buffers are plain RAM: never reset, border masking hides stale contents.
    always_ff @(posedge clk) begin
        if (w_acc && w_inr) begin
            r_lb1[w_idx] <= r_y;
            r_lb2[w_idx] <= w_l1;
        end
    end

    assign post_frame_vsync = r_vs[6];
    assign post_frame_href  = r_hr[6];
    assign post_frame_clken = r_ck[6];
    assign post_img_Bit     = r_bit;
endmodule

// File: tb/tb_vip_rgb_sobel_edge.sv
// tb_vip_rgb_sobel_edge: directed and random frames checked against a frame-level Sobel model.
module tb_vip_rgb_sobel_edge;
    localparam int H = 20;
    localparam int V = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vs = 1'b0, hr = 1'b0, ck = 1'b0;
    logic [7:0] pr = '0, pg = '0, pb = '0, th = '0;
    logic       o_vs, o_hr, o_ck, o_bit;

    int checks = 0;
    int errors = 0;
    int bad_gap = 0;
    int ones;
    int seen;

    logic [7:0] img_r [V][H];
    logic [7:0] img_g [V][H];
    logic [7:0] img_b [V][H];
    bit exp_q[$];
    bit got_q[$];

    always #5 clk = ~clk;

    vip_rgb_sobel_edge #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ck),
        .per_img_red(pr), .per_img_green(pg), .per_img_blue(pb),
        .Sobel_Threshold(th),
        .post_frame_vsync(o_vs), .post_frame_href(o_hr), .post_frame_clken(o_ck),
        .post_img_Bit(o_bit)
    );

    always @(negedge clk) begin
        if (o_ck) got_q.push_back(o_bit);
        if (!o_ck && o_bit) bad_gap++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic fill_halves(input logic [23:0] lo, input logic [23:0] hi);
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                {img_r[y][x], img_g[y][x], img_b[y][x]} = (x < H / 2) ? lo : hi;
    endtask

    task automatic fill_rand();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                img_r[y][x] = 8'($urandom_range(0, 255));
                img_g[y][x] = 8'($urandom_range(0, 255));
                img_b[y][x] = 8'($urandom_range(0, 255));
            end
    endtask

    // Luma per pixel, then gradient magnitude squared against threshold squared, borders forced low.
    task automatic model(input int t);
        int yv [V][H];
        int gx, gy;
        exp_q.delete();
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                yv[y][x] = (77 * int'(img_r[y][x]) + 150 * int'(img_g[y][x]) + 29 * int'(img_b[y][x])) / 256;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++) begin
                if (y < 2 || x < 2) exp_q.push_back(1'b0);
                else begin
                    gx = (yv[y-2][x] + 2 * yv[y-1][x] + yv[y][x]) - (yv[y-2][x-2] + 2 * yv[y-1][x-2] + yv[y][x-2]);
                    gy = (yv[y-2][x-2] + 2 * yv[y-2][x-1] + yv[y-2][x]) - (yv[y][x-2] + 2 * yv[y][x-1] + yv[y][x]);
                    exp_q.push_back(gx * gx + gy * gy > t * t);
                end
            end
    endtask

    task automatic run_frame(input string tag, input int t, input bit gaps, output int n_ones);
        int c, x;
        model(t);
        th = 8'(t);
        got_q.delete();
        vs = 1'b0; hr = 1'b0; ck = 1'b0;
        repeat (4) cyc();
        vs = 1'b1;
        repeat (3) cyc();
        for (int y = 0; y < V; y++) begin
            hr = 1'b1;
            c = 0;
            x = 0;
            while (x < H) begin
                if (gaps && (c % 3 == 2)) ck = 1'b0;
                else begin
                    ck = 1'b1;
                    pr = img_r[y][x]; pg = img_g[y][x]; pb = img_b[y][x];
                    x++;
                end
                cyc();
                c++;
            end
            hr = 1'b0; ck = 1'b0;
            repeat (3) cyc();
        end
        vs = 1'b0;
        repeat (10) cyc();
        chk({tag, "_count"}, got_q.size(), H * V);
        n_ones = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_px%0d", tag, i), int'(got_q[i]), int'(exp_q[i]));
            n_ones += int'(got_q[i]);
        end
        chk({tag, "_bit_without_clken"}, bad_gap, 0);
    endtask

    initial begin
        repeat (3) cyc();
        chk("reset_outputs", {o_vs, o_hr, o_ck, o_bit}, 0);
        rst = 1'b0;
        repeat (3) cyc();
        vs = 1'b1;
        repeat (8) cyc();
        chk("vsync_high_after_7", o_vs, 1);
        hr = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 6) chk("href_rise_k6", o_hr, 0);
            if (k == 7) chk("href_rise_k7", o_hr, 1);
        end
        hr = 1'b0;
        repeat (8) cyc();
        vs = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k == 6) chk("vsync_fall_k6", o_vs, 1);
            if (k == 7) chk("vsync_fall_k7", o_vs, 0);
        end
        repeat (4) cyc();

        fill_halves(24'h000000, 24'hFFFFFF);
        run_frame("half_0_255_th128", 128, 1'b0, ones);
        chk("half_0_255_ones", ones, 2 * (V - 2));
        fill_halves(24'h000000, 24'h202020);
        run_frame("half_0_32_th128", 128, 1'b0, ones);
        chk("half_0_32_th128_ones", ones, 0);
        run_frame("half_0_32_th127", 127, 1'b0, ones);
        chk("half_0_32_th127_ones", ones, 2 * (V - 2));
        fill_halves(24'hFF0000, 24'h323232);
        run_frame("red_th103", 103, 1'b0, ones);
        chk("red_th103_ones", ones, 2 * (V - 2));
        run_frame("red_th104", 104, 1'b0, ones);
        chk("red_th104_ones", ones, 0);
        fill_halves(24'hFFFFFF, 24'hE6E6E6);
        run_frame("white_th99", 99, 1'b0, ones);
        chk("white_th99_ones", ones, 2 * (V - 2));
        run_frame("white_th100", 100, 1'b0, ones);
        chk("white_th100_ones", ones, 0);
        for (int i = 0; i < 3; i++) begin
            fill_rand();
            run_frame($sformatf("rand%0d", i), int'($urandom_range(60, 255)), 1'b0, ones);
        end
        fill_halves(24'h000000, 24'hFFFFFF);
        run_frame("gap_half", 128, 1'b1, ones);
        chk("gap_half_ones", ones, 2 * (V - 2));
        fill_rand();
        run_frame("gap_rand", int'($urandom_range(60, 255)), 1'b1, ones);

        vs = 1'b1; hr = 1'b1; ck = 1'b1;
        for (int k = 0; k < 12; k++) begin
            pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
            cyc();
        end
        chk("stream_href_before_reset", o_hr, 1);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("midreset_outputs%0d", k), {o_vs, o_hr, o_ck, o_bit}, 0);
        end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            pr = 8'($urandom); pg = 8'($urandom); pb = 8'($urandom);
            cyc();
            seen |= int'({o_vs, o_hr, o_ck, o_bit});
        end
        chk("aborted_frame_dark", seen, 0);
        hr = 1'b0; ck = 1'b0;
        fill_rand();
        run_frame("after_reset", int'($urandom_range(60, 255)), 1'b0, ones);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog observed timeout expected finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
